// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver control slice: default widths,
// the legal oversampling ratios and the FSM state encoding.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_W_DEF    = 6;
  localparam int BIT_W_DEF      = 4;

  // Oversampling ratios the sampler and counters are built for.
  typedef enum int {
    PRESC_X8  = 8,
    PRESC_X16 = 16,
    PRESC_X32 = 32
  } presc_e;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;
  localparam rx_state_t ST_CHECK  = 3'd5;
  localparam rx_state_t ST_DONE   = 3'd6;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters for the UART receiver.
// Priority: clear, then bit_clear_keep_edge, then enable.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int BIT_W   = BIT_W_DEF
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               enable,
  input  logic               clear,
  input  logic               bit_clear_keep_edge,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               edge_last
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d, edge_nxt;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

  // Compare against the live prescale value; it is static while a frame runs.
  assign edge_last = (edge_cnt_q == prescale - PRESC_W'(1));
  assign edge_nxt  = edge_last ? '0 : edge_cnt_q + PRESC_W'(1);

  // Next-count selection; keep-edge restarts the bit index for a back-to-back start bit.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clear) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_clear_keep_edge) begin
      edge_cnt_d = edge_nxt;
      bit_cnt_d  = '0;
    end else if (enable) begin
      edge_cnt_d = edge_nxt;
      if (edge_last) begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control stage: frame sequencing, counter control and the
// enables for the sampler, deserializer and start/parity/stop checkers.
//
// state  | meaning
// IDLE   | line idle, counters held at 0
// START  | start bit, start checker enabled
// DATA   | data bits 1..DATA_WIDTH, deserializer shifting
// PARITY | parity bit (only when parity latched on)
// STOP   | stop bit being sampled, not yet checked
// CHECK  | one cycle, stop/parity checkers evaluate
// DONE   | one cycle, data_valid decided, back-to-back start accepted
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF,
  parameter int BIT_W      = BIT_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               PAR_EN,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               busy
);

  rx_state_t state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      edge_last;
  logic      cnt_en, cnt_clr, cnt_keep;

  // Next-state logic; parity enable is captured only when a frame starts from idle.
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d  = ST_START;
          par_en_d = PAR_EN;
        end
      end
      ST_START: begin
        if (edge_last) begin
          state_d = strt_glitch ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (edge_last && (bit_cnt == BIT_W'(DATA_WIDTH))) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (edge_last) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (edge_last) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = RX_IN ? ST_IDLE : ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and latched parity enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  // A back-to-back start bit began in CHECK, so its edge count carries on.
  assign cnt_clr  = (state_d == ST_IDLE);
  assign cnt_keep = (state_q == ST_DONE) && (state_d == ST_START);
  assign cnt_en   = (state_q != ST_IDLE);

  edge_bit_counter #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_cnt (
    .clk_sys             (CLK),
    .rst_b               (RST),
    .prescale            (prescale),
    .enable              (cnt_en),
    .clear               (cnt_clr),
    .bit_clear_keep_edge (cnt_keep),
    .edge_cnt            (edge_cnt),
    .bit_cnt             (bit_cnt),
    .edge_last           (edge_last)
  );

  // Sampler stays on through CHECK/DONE so a back-to-back start bit is caught mid-bit.
  assign busy        = (state_q != ST_IDLE);
  assign dat_samp_en = busy;
  assign strt_chk_en = (state_q == ST_START);
  assign deser_en    = (state_q == ST_DATA);
  assign stp_chk_en  = (state_q == ST_CHECK);
  assign par_chk_en  = (state_q == ST_CHECK) && par_en_q;
  assign data_valid  = (state_q == ST_DONE) && !stp_err && !(par_en_q && par_err);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame-position reference model with a per-cycle
// compare, plus directed frames with literal timing expectations and random frames.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW), .BIT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit line_q[$];

  // Serial line: one queued level per cycle, idle high when the queue is empty.
  initial forever begin
    @(negedge CLK);
    #1;
    if (line_q.size() > 0) RX_IN = line_q.pop_front();
    else RX_IN = 1'b1;
  end

  // Stop checker stand-in: samples mid-bit, flags a low stop bit after CHECK.
  logic samp_q;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stp_err <= 1'b0;
      samp_q  <= 1'b1;
    end else begin
      if (dat_samp_en && edge_cnt == (prescale >> 1)) samp_q <= RX_IN;
      if (stp_chk_en && edge_cnt == '0) stp_err <= ~samp_q;
    end
  end

  // Reference model: position t (cycles since the start bit's edge 0) within a frame.
  bit m_act = 1'b0;
  bit m_par = 1'b0;
  bit m_stop_ok = 1'b0;
  int m_t = 0;

  function automatic int m_last();
    return DW + 1 + (m_par ? 1 : 0);
  endfunction

  function automatic int m_tend();
    return int'(prescale) * (m_last() + 1);
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_par <= 1'b0;
    end else if (!m_act) begin
      if (!RX_IN) begin
        m_act <= 1'b1;
        m_t   <= 0;
        m_par <= PAR_EN;
      end
    end else begin
      if (m_t == m_tend() + 1) begin
        if (!RX_IN) m_t <= 2;
        else m_act <= 1'b0;
      end else if (m_t == int'(prescale) - 1 && strt_glitch) begin
        m_act <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
      if (m_t == int'(prescale) * m_last() + int'(prescale) / 2) m_stop_ok <= RX_IN;
    end
  end

  function automatic logic [16:0] act_vec();
    return {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
            stp_chk_en, data_valid, busy};
  endfunction

  function automatic logic [16:0] exp_vec();
    int p, b, e;
    bit chk, done, deser, dv;
    if (!m_act) return '0;
    p     = int'(prescale);
    b     = m_t / p;
    e     = m_t % p;
    chk   = (m_t == m_tend());
    done  = (m_t == m_tend() + 1);
    deser = (b >= 1) && (b <= DW) && !chk && !done;
    dv    = done && m_stop_ok && !(m_par && par_err);
    return {PW'(e), BW'(b), 1'b1, deser, (b == 0), chk && m_par, chk, dv, 1'b1};
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge CLK);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_vec(), exp_vec());
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_level(input bit v, input int n);
    for (int i = 0; i < n; i++) line_q.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] d, input int p, input bit par,
                            input bit stop_v, input int stop_len);
    push_level(1'b0, p);
    for (int i = 0; i < DW; i++) push_level(d[i], p);
    if (par) push_level(^d, p);
    push_level(stop_v, stop_len);
  endtask

  // Runs until the DUT has started and returned idle with the line drained.
  task automatic run_frame(input int budget, output int c_chk, output int c_dv,
                           output int c_idle, output int n_dv, output bit saw_deser,
                           output int stop_bit, output int pe, output int pb, output int pbusy);
    int n, prev_bit;
    bit started;
    c_chk = -1; c_dv = -1; c_idle = -1; n_dv = 0; saw_deser = 0; stop_bit = -1;
    pe = -1; pb = -1; pbusy = -1; started = 0; n = 0; prev_bit = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (!started && busy) begin
        started = 1;
        n = 0;
      end
      if (started) begin
        if (c_dv >= 0 && n == c_dv + 1) begin
          pe = int'(edge_cnt); pb = int'(bit_cnt); pbusy = int'(busy);
        end
        if (stp_chk_en && c_chk < 0) begin
          c_chk = n;
          stop_bit = prev_bit;
        end
        if (data_valid) begin
          n_dv++;
          if (c_dv < 0) c_dv = n;
        end
        if (deser_en) saw_deser = 1;
        if (!busy && line_q.size() == 0) begin
          c_idle = n;
          break;
        end
        prev_bit = int'(bit_cnt);
        n++;
      end
    end
    check("frame_completes", (c_idle >= 0) ? 1 : 0, 1);
  endtask

  task automatic setup(input int p, input bit par, input bit perr, input bit glitch);
    @(negedge CLK);
    #1;
    prescale    = PW'(p);
    PAR_EN      = par;
    par_err     = perr;
    strt_glitch = glitch;
  endtask

  int c_chk, c_dv, c_idle, n_dv, stop_bit, pe, pb, pbusy;
  bit saw_deser;

  initial begin
    #1;
    check("reset_outputs", int'(act_vec()), 0);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Clean frame, prescale 8, 0xA5
    setup(PRESC_X8, 0, 0, 0);
    push_frame(8'hA5, 8, 0, 1, 8);
    run_frame(400, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("clean_check_cycle", c_chk, 80);
    check("clean_dv_cycle", c_dv, 81);
    check("clean_dv_count", n_dv, 1);
    check("clean_idle_cycle", c_idle, 82);
    check("clean_stop_index", stop_bit, 9);

    // Parity frame, prescale 16, 0x3C, parity good then parity error
    setup(PRESC_X16, 1, 0, 0);
    push_frame(8'h3C, 16, 1, 1, 16);
    run_frame(800, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("par_stop_index", stop_bit, 10);
    check("par_dv_count", n_dv, 1);
    check("par_check_cycle", c_chk, 176);
    setup(PRESC_X16, 1, 1, 0);
    push_frame(8'h3C, 16, 1, 1, 16);
    run_frame(800, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("parerr_dv_count", n_dv, 0);

    // Stop error
    setup(PRESC_X8, 0, 0, 0);
    push_frame(8'h81, 8, 0, 0, 8);
    run_frame(400, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("stoperr_dv_count", n_dv, 0);
    check("stoperr_idle_cycle", c_idle, 82);

    // Start glitch
    setup(PRESC_X8, 0, 0, 1);
    push_level(1'b0, 2);
    run_frame(100, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("glitch_idle_cycle", c_idle, 8);
    check("glitch_deser_seen", int'(saw_deser), 0);
    check("glitch_dv_count", n_dv, 0);
    setup(PRESC_X8, 0, 0, 0);

    // Back-to-back: second start bit begins in the CHECK cycle
    push_frame(8'hC3, 8, 0, 1, 9);
    push_frame(8'h5E, 8, 0, 1, 8);
    run_frame(600, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("b2b_dv_count", n_dv, 2);
    check("b2b_restart_edge", pe, 2);
    check("b2b_restart_bit", pb, 0);
    check("b2b_restart_busy", pbusy, 1);

    // Reset during DATA at bit_cnt 4
    setup(PRESC_X8, 0, 0, 0);
    push_frame(8'h5A, 8, 0, 1, 8);
    begin
      int waited;
      waited = 0;
      while (!(deser_en && bit_cnt == BW'(4)) && waited < 300) begin
        @(negedge CLK);
        waited++;
      end
      check("reach_bit4", (waited < 300) ? 1 : 0, 1);
    end
    #3 RST = 1'b0;
    #1 check("midframe_reset_outputs", int'(act_vec()), 0);
    line_q.delete();
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    push_frame(8'h96, 8, 0, 1, 8);
    run_frame(400, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
    check("post_reset_dv_count", n_dv, 1);
    check("post_reset_check_cycle", c_chk, 80);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      int p, sel, exp_dv;
      bit par, perr, stop_v, b2b;
      logic [7:0] d0, d1;
      sel    = $urandom_range(0, 2);
      p      = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
      par    = 1'($urandom_range(0, 1));
      perr   = ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 3) != 0);
      b2b    = ($urandom_range(0, 2) == 0);
      d0     = 8'($urandom);
      d1     = 8'($urandom);
      setup(p, par, perr, 0);
      push_frame(d0, p, par, stop_v, b2b ? p + 1 : p);
      if (b2b) push_frame(d1, p, par, 1'b1, p);
      push_level(1'b1, $urandom_range(0, 3));
      exp_dv = (stop_v && !(par && perr)) ? 1 : 0;
      if (b2b && !(par && perr)) exp_dv++;
      run_frame(2000, c_chk, c_dv, c_idle, n_dv, saw_deser, stop_bit, pe, pb, pbusy);
      check("rand_dv_count", n_dv, exp_dv);
      check("rand_stop_index", stop_bit, DW + 1 + (par ? 1 : 0));
    end

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
